// File: rtl/pygmy_rom_pkg.sv
// Shared encodings for the ROM read-port arbiter: access sizes and the
// one-deep response register that pairs a grant with its returning word.
package pygmy_rom_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [2:0] {
    RESP_NONE   = 3'd0,
    RESP_IF_OK  = 3'd1,
    RESP_LS_OK  = 3'd2,
    RESP_IF_ERR = 3'd3,
    RESP_LS_ERR = 3'd4
  } resp_e;

  typedef struct packed {
    resp_e      kind;
    logic [1:0] off;
    logic [1:0] hb;
  } resp_t;

  localparam resp_t RESP_IDLE = '{kind: RESP_NONE, off: 2'b00, hb: 2'b00};

endpackage

// File: rtl/rom_lane_fmt.sv
// Extracts a zero-extended byte, half or word from a 32-bit ROM word.
module rom_lane_fmt
  import pygmy_rom_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  hb,
  output logic [31:0] data
);

  logic [3:0][7:0] lanes;
  assign lanes = word;

  always_comb begin
    data = '0;
    case (hb)
      HB_BYTE: data[7:0]  = lanes[off];
      HB_HALF: data[15:0] = off[1] ? word[31:16] : word[15:0];
      default: data       = word;
    endcase
  end

endmodule

// File: rtl/urom_arbiter.sv
// Two-requester arbiter for the single synchronous ROM read port: fixed LS
// priority with an IF starvation guard, access checks, 1-cycle responses.
module urom_arbiter
  import pygmy_rom_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int MAX_STREAK = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_err_o,
  input  logic          ls_req_i,
  input  logic [31:0]   ls_addr_i,
  input  logic [1:0]    ls_hb_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [31:0]   ls_rdata_o,
  output logic          ls_err_o,
  output logic          rom_en_o,
  output logic [AW-1:0] rom_addr_o,
  input  logic [31:0]   rom_rdata_i
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  resp_t         resp_q, resp_d;

  logic          ls_win, if_win, any_gnt;
  logic [31:0]   sel_addr;
  logic          out_of_range, misaligned, acc_err;
  logic [31:0]   ls_fmt;

  // LS has priority until IF has watched MAX_STREAK LS grants go by.
  assign ls_win   = ls_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  assign if_win   = if_req_i && !ls_win;
  assign if_gnt_o = rst_ni & if_win;
  assign ls_gnt_o = rst_ni & ls_win;
  assign any_gnt  = if_gnt_o | ls_gnt_o;

  assign sel_addr     = ls_win ? ls_addr_i : if_addr_i;
  assign out_of_range = (sel_addr >> (AW + 2)) != 32'd0;

  always_comb begin
    misaligned = 1'b0;
    if (ls_win) begin
      case (ls_hb_i)
        HB_BYTE: misaligned = 1'b0;
        HB_HALF: misaligned = sel_addr[0];
        default: misaligned = sel_addr[1:0] != 2'b00;
      endcase
    end else begin
      misaligned = sel_addr[1:0] != 2'b00;
    end
  end

  assign acc_err    = out_of_range | misaligned;
  assign rom_en_o   = any_gnt & ~acc_err;
  assign rom_addr_o = rom_en_o ? sel_addr[AW+1:2] : '0;

  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt_o) begin
      streak_d = '0;
    end else if (ls_gnt_o && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_comb begin
    resp_d = RESP_IDLE;
    if (ls_gnt_o) begin
      resp_d.kind = acc_err ? RESP_LS_ERR : RESP_LS_OK;
      resp_d.off  = ls_addr_i[1:0];
      resp_d.hb   = ls_hb_i;
    end else if (if_gnt_o) begin
      resp_d.kind = acc_err ? RESP_IF_ERR : RESP_IF_OK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= '0;
      resp_q   <= RESP_IDLE;
    end else begin
      streak_q <= streak_d;
      resp_q   <= resp_d;
    end
  end

  rom_lane_fmt u_fmt (
    .word (rom_rdata_i),
    .off  (resp_q.off),
    .hb   (resp_q.hb),
    .data (ls_fmt)
  );

  always_comb begin
    if_rvalid_o = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = '0;
    ls_rvalid_o = 1'b0;
    ls_err_o    = 1'b0;
    ls_rdata_o  = '0;
    case (resp_q.kind)
      RESP_IF_OK: begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = rom_rdata_i;
      end
      RESP_IF_ERR: begin
        if_rvalid_o = 1'b1;
        if_err_o    = 1'b1;
      end
      RESP_LS_OK: begin
        ls_rvalid_o = 1'b1;
        ls_rdata_o  = ls_fmt;
      end
      RESP_LS_ERR: begin
        ls_rvalid_o = 1'b1;
        ls_err_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/urom_arbiter.md
Name: urom_arbiter

Overview:
- Shares the single synchronous read port of the boot/program ROM between two requesters: instruction fetch (IF) and load/store unit loads (LS).
- Performs fixed-priority arbitration with a starvation guard and drives the ROM word address and enable.
- Formats LS byte/half/word reads from the returned word and returns responses with 1-cycle latency.
- Sits between the core's fetch/LSU request ports and the ROM array.

Parameters:
- DEPTH, 1024: ROM size in 32-bit words. Word index width AW = $clog2(DEPTH).
- MAX_STREAK, 4: maximum consecutive LS grants while an IF request is pending, after which IF is granted.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  32  fetch byte address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch response valid.
- if_rdata_o  out  32  fetch word.
- if_err_o  out  1  fetch error (misaligned or out of range); qualifies if_rvalid_o.
- ls_req_i  in  1  load request.
- ls_addr_i  in  32  load byte address.
- ls_hb_i  in  2  size: 00 byte, 01 half, 10/11 word.
- ls_gnt_o  out  1  load request accepted this cycle.
- ls_rvalid_o  out  1  load response valid.
- ls_rdata_o  out  32  zero-extended load data.
- ls_err_o  out  1  load error; qualifies ls_rvalid_o.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  AW  ROM word index.
- rom_rdata_i  in  32  ROM word, valid the cycle after rom_en_o.

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous, active-low.
- Reset state: all outputs 0; resp_q=NONE; streak counter 0.
- Arbitration (combinational, cycle N): at most one gnt per cycle.
  - LS wins if ls_req_i, unless if_req_i && streak==MAX_STREAK; in that case IF wins.
  - IF wins if only if_req_i.
  - gnt_o is asserted in the same cycle as the winning req.
  - The loser holds its request stable until granted.
- Streak counter:
  - Increments on an LS grant while if_req_i=1, saturating at MAX_STREAK.
  - Clears on an IF grant, or in any cycle with if_req_i=0.
- Access checks on the granted request (cycle N):
  - Word index = addr[AW+1:2].
  - Out of range when addr[31:AW+2] != 0.
  - IF misaligned when addr[1:0] != 0.
  - LS half misaligned when addr[0]=1.
  - LS word misaligned when addr[1:0] != 0.
  - Legal: rom_en_o=1, rom_addr_o=index.
  - Error: rom_en_o=0, and the grant is still given.
- Response register resp_q ∈ {NONE, IF_OK, LS_OK, IF_ERR, LS_ERR}, loaded every cycle from the cycle-N outcome. NONE if no grant. Stores addr[1:0] and hb for LS.
- Cycle N+1 outputs (combinational from resp_q and rom_rdata_i):
  - IF_OK: if_rvalid_o=1, if_rdata_o=rom_rdata_i.
  - LS_OK: ls_rvalid_o=1; ls_rdata_o formatted as follows:
    - byte: lane addr[1:0], zero-extended.
    - half: addr[1]=0 gives [15:0], addr[1]=1 gives [31:16], zero-extended.
    - word: the full word.
  - *_ERR: the matching rvalid and err are 1, data 0.
  - Inactive-port rdata is 0.
- Back-to-back: a new grant may be issued every cycle. Responses come strictly in grant order, and only one is outstanding per cycle.
- Simultaneous IF and LS requests at streak < MAX_STREAK: LS granted, IF stalls.
- Reset mid-access: an asserted rst_ni=0 immediately clears resp_q, so the pending response is dropped (no rvalid). The streak counter also clears.
- No combinational path from rom_rdata_i to any gnt_o or rom_* output.

Decomposition:
- Package pygmy_rom_pkg:
  - Size encodings HB_BYTE=2'b00, HB_HALF=2'b01, HB_WORD=2'b10.
  - resp_q state encoding.
- Sub-module rom_lane_fmt: combinational byte/half/word extractor (inputs: word, addr[1:0], hb; output: 32-bit zero-extended data).
- The arbiter, checks and response FSM stay in urom_arbiter.

Test Plan:
- Reset: hold rst_ni=0 with requests active -> all outputs 0. Release, then IF req addr 0x8 -> if_gnt_o same cycle, rom_addr_o=2, next cycle if_rvalid_o=1 and if_rdata_o=ROM[2].
- LS byte and half, ROM[1]=0xA1B2C3D4:
  - byte addr 0x5 -> ls_rdata_o=0x000000C3.
  - half addr 0x6 -> 0x0000A1B2.
  - word addr 0x4 -> 0xA1B2C3D4.
- Contention: IF and LS requesting continuously with MAX_STREAK=4 -> grant pattern LS,LS,LS,LS,IF repeating. Responses arrive in grant order, one cycle after each grant.
- Errors:
  - LS half addr 0x3 -> gnt, rom_en_o=0, next cycle ls_rvalid_o=1, ls_err_o=1, data 0.
  - IF addr 0x2 -> if_err_o=1.
  - LS addr 0x1000 (DEPTH=1024) -> ls_err_o=1.
- Reset mid-access: grant LS at cycle N, assert rst_ni=0 in cycle N -> no ls_rvalid_o at N+1. After release, the streak counter is 0 (the next contention grants LS 4 times first).
- Idle interleave: alternate IF-only and LS-only requests each cycle -> every request granted on its first cycle, and the streak counter stays 0.
